uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 108 ++++++++++
 tb/tb_uart_rx.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop input synchronizer and mid-bit sampling.
// Optional stop-bit framing check: define UART_RX_STOP_CHECK_EN.
module uart_rx #(
  parameter int unsigned wait_period = 1250
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RX,
  output logic [7:0] DATA,
  output logic       NEW_DATA
);

  localparam int unsigned CW = (wait_period > 1) ? $clog2(wait_period) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(wait_period / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(wait_period - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  state_t        state, state_next;
  logic          rx_meta, rx_s, rx_prev;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    idx, idx_next;
  logic [7:0]    shift, shift_next, data_next;
  logic          new_data_next;
  logic          stop_ok;

`ifdef UART_RX_STOP_CHECK_EN
  assign stop_ok = rx_s;
`else
  assign stop_ok = 1'b1;
`endif

  // rx_prev follows rx_s in every state so a start edge right after a stop mid-sample is seen
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt      <= '0;
      idx      <= '0;
      shift    <= '0;
      DATA     <= '0;
      NEW_DATA <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      idx      <= idx_next;
      shift    <= shift_next;
      DATA     <= data_next;
      NEW_DATA <= new_data_next;
    end
  end

  always_comb begin
    state_next    = state;
    cnt_next      = cnt + CW'(1);
    idx_next      = idx;
    shift_next    = shift;
    data_next     = DATA;
    new_data_next = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_next = '0;
        if (rx_prev && !rx_s) state_next = ST_START;
      end
      ST_START: begin
        if (cnt == HALF_LAST) begin
          cnt_next   = '0;
          idx_next   = '0;
          state_next = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_next        = '0;
          shift_next[idx] = rx_s;
          idx_next        = idx + 3'd1;
          if (idx == 3'd7) state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_next   = '0;
          state_next = ST_IDLE;
          if (stop_ok) begin
            data_next     = shift;
            new_data_next = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx: frame-level scoreboard of bytes and latency.
// Honours UART_RX_STOP_CHECK_EN the same way as the design.
module tb_uart_rx;

  localparam int unsigned W = 16;
  localparam int NOM_LAT = (19 * W) / 2 + 3;

`ifdef UART_RX_STOP_CHECK_EN
  localparam bit STOP_CHECK = 1'b1;
`else
  localparam bit STOP_CHECK = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       RX = 1'b1;
  logic [7:0] DATA;
  logic       NEW_DATA;

  uart_rx #(.wait_period(W)) dut (
    .CLK(CLK), .RESET(RESET), .RX(RX), .DATA(DATA), .NEW_DATA(NEW_DATA)
  );

  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int          cyc = 0;
  logic [7:0]  exp_q[$];
  int          start_q[$];
  logic [7:0]  last_data = 8'h00;
  logic        prev_nd = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: every pulse must match the oldest outstanding frame and arrive in the latency window
  always @(negedge CLK) begin
    int lat;
    logic [7:0] e;
    if (NEW_DATA) begin
      check("nd_single_cycle", 32'(prev_nd), 32'(0));
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(1), 32'(0));
      end else begin
        e   = exp_q.pop_front();
        lat = cyc - start_q.pop_front();
        check("data", 32'(DATA), 32'(e));
        if (lat < NOM_LAT - 2 || lat > NOM_LAT + 2) check("latency", 32'(lat), 32'(NOM_LAT));
        else check("latency", 32'(lat), 32'(lat > NOM_LAT ? lat : NOM_LAT) - 32'(lat > NOM_LAT ? 0 : NOM_LAT - lat));
        last_data = e;
      end
    end
    prev_nd = NEW_DATA;
  end

  task automatic hold(input logic v, input int n);
    RX = v;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    if (stop_v || !STOP_CHECK) begin
      exp_q.push_back(b);
      start_q.push_back(cyc);
    end
    hold(1'b0, W);
    for (int i = 0; i < 8; i++) hold(b[i], W);
    hold(stop_v, W);
  endtask

  task automatic settle_and_check(input string tag);
    hold(1'b1, 2 * W);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'(0));
    check({tag, "_data_hold"}, 32'(DATA), 32'(last_data));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic       sv;
    repeat (4) @(posedge CLK);
    #1;
    check("reset_data", 32'(DATA), 32'(0));
    check("reset_new_data", 32'(NEW_DATA), 32'(0));
    RESET = 1'b0;
    hold(1'b1, W);
    check("post_reset_idle_nd", 32'(NEW_DATA), 32'(0));

    send_frame(8'h53, 1'b1);
    settle_and_check("frame_53");

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    settle_and_check("back_to_back");

    hold(1'b0, W / 4);
    settle_and_check("glitch");
    send_frame(8'hA5, 1'b1);
    settle_and_check("frame_a5");

    send_frame(8'h3C, 1'b0);
    settle_and_check("bad_stop_3c");

    hold(1'b0, W);
    b = 8'h6B;
    for (int i = 0; i < 4; i++) hold(b[i], W);
    hold(b[4], W / 2);
    RESET = 1'b1;
    #1;
    check("midframe_reset_data", 32'(DATA), 32'(0));
    check("midframe_reset_nd", 32'(NEW_DATA), 32'(0));
    last_data = 8'h00;
    hold(1'b1, 3);
    RESET = 1'b0;
    settle_and_check("after_reset");
    send_frame(8'h81, 1'b1);
    settle_and_check("frame_81");

    for (int k = 0; k < 12; k++) begin
      b  = 8'($urandom);
      sv = ($urandom_range(0, 3) != 0);
      send_frame(b, sv);
      if (sv) hold(1'b1, $urandom_range(0, W));
      else    hold(1'b1, W + $urandom_range(0, W));
    end
    settle_and_check("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
